// File: rtl/gate_selftest_seq_if.sv
// Stimulus/response bundle between the self-test sequencer and the gate block.
// slave: the sequencer. master: whatever drives start and supplies gate results.
interface gate_selftest_seq_if #(
  parameter int unsigned ERR_W = 5
);
  logic             start;
  logic             a;
  logic             b;
  logic             and_g;
  logic             or_g;
  logic             not_a_g;
  logic             xor_g;
  logic             xnor_g;
  logic             nand_g;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport slave (
    input  start, and_g, or_g, not_a_g, xor_g, xnor_g, nand_g,
    output a, b, busy, done, pass, err_count, fail_vec
  );

  modport master (
    output start, and_g, or_g, not_a_g, xor_g, xnor_g, nand_g,
    input  a, b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_selftest_seq.sv
// Self-test sequencer: walks a/b through 00,01,10,11, holds each vector for
// HOLD_CYCLES, then checks all six gate results against a golden model.
module gate_selftest_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ERR_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_selftest_seq_if.slave   bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned SUM_W  = ERR_W + 3;
  localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'((64'd1 << ERR_W) - 64'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        fv_q, fv_d;

  logic [5:0]        exp_c;
  logic [5:0]        got_c;
  logic [5:0]        mism_c;
  logic [2:0]        pop_c;
  logic [SUM_W-1:0]  sum_c;
  logic [SUM_W-1:0]  sat_c;

  // Golden comparison against the registered stimulus, with saturating accumulate
  always_comb begin
    exp_c  = {a_q & b_q, a_q | b_q, ~a_q, a_q ^ b_q, ~(a_q ^ b_q), ~(a_q & b_q)};
    got_c  = {bus.and_g, bus.or_g, bus.not_a_g, bus.xor_g, bus.xnor_g, bus.nand_g};
    mism_c = exp_c ^ got_c;
    pop_c  = 3'd0;
    for (int i = 0; i < 6; i++) begin
      pop_c = pop_c + 3'(mism_c[i]);
    end
    sum_c = SUM_W'(err_q) + SUM_W'(pop_c);
    sat_c = (sum_c > ERR_MAX) ? ERR_MAX : sum_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_DRIVE;
          vec_d   = 2'd0;
          hold_d  = '0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fv_d    = 4'd0;
        end
      end
      S_DRIVE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_SAMPLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + HOLD_W'(1);
        end
      end
      S_SAMPLE: begin
        err_d = ERR_W'(sat_c);
        if (pop_c != 3'd0) begin
          fv_d[vec_q] = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = S_DONE;
          pass_d  = (sat_c == '0);
        end else begin
          state_d = S_DRIVE;
          vec_d   = vec_q + 2'd1;
          a_d     = vec_d[1];
          b_d     = vec_d[0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      hold_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fv_q;

endmodule

// File: tb/tb_gate_selftest_seq.sv
// Bench for gate_selftest_seq: two sequencers (hold 4 / 5-bit count and
// hold 1 / 4-bit count) driven by a configurable gate model; expected results
// are queued at stimulus time and checked by monitors when done rises.
module tb_gate_selftest_seq;

  localparam int unsigned H0 = 4;
  localparam int unsigned E0 = 5;
  localparam int unsigned H1 = 1;
  localparam int unsigned E1 = 4;

  typedef struct {
    int pass;
    int err;
    int fv;
    int lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   mode;   // 0 correct, 1 xor stuck at 0, 2 all outputs inverted
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  gate_selftest_seq_if #(.ERR_W(E0)) if0 ();
  gate_selftest_seq_if #(.ERR_W(E1)) if1 ();

  gate_selftest_seq #(.HOLD_CYCLES(H0), .ERR_W(E0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  gate_selftest_seq #(.HOLD_CYCLES(H1), .ERR_W(E1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate block model with optional fault injection; order and,or,not_a,xor,xnor,nand
  function automatic logic [5:0] gates(input logic a, input logic b, input int m);
    logic [5:0] g;
    g = {a & b, a | b, ~a, a ^ b, ~(a ^ b), ~(a & b)};
    if (m == 1) g[2] = 1'b0;
    if (m == 2) g = ~g;
    return g;
  endfunction

  assign {if0.and_g, if0.or_g, if0.not_a_g, if0.xor_g, if0.xnor_g, if0.nand_g} = gates(if0.a, if0.b, mode);
  assign {if1.and_g, if1.or_g, if1.not_a_g, if1.xor_g, if1.xnor_g, if1.nand_g} = gates(if1.a, if1.b, mode);

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor for dut0: vector sequence while busy, scoreboard pop on done rise
  int   b0_cyc;
  logic busy0_p, done0_p;
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      busy0_p = 1'b0;
      done0_p = 1'b0;
    end else begin
      if (if0.busy && !busy0_p) b0_cyc = cyc;
      if (if0.busy) chk("dut0 ab", int'({if0.a, if0.b}), (cyc - b0_cyc) / int'(H0 + 1));
      if (if0.done && !done0_p) begin
        chk("dut0 expected_run", int'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("dut0 pass",      int'(if0.pass),      e.pass);
          chk("dut0 err_count", int'(if0.err_count), e.err);
          chk("dut0 fail_vec",  int'(if0.fail_vec),  e.fv);
          chk("dut0 latency",   cyc - b0_cyc,        e.lat);
          chk("dut0 ab_done",   int'({if0.a, if0.b}), 3);
        end
      end
      busy0_p = if0.busy;
      done0_p = if0.done;
    end
  end

  // Monitor for dut1
  int   b1_cyc;
  logic busy1_p, done1_p;
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      busy1_p = 1'b0;
      done1_p = 1'b0;
    end else begin
      if (if1.busy && !busy1_p) b1_cyc = cyc;
      if (if1.busy) chk("dut1 ab", int'({if1.a, if1.b}), (cyc - b1_cyc) / int'(H1 + 1));
      if (if1.done && !done1_p) begin
        chk("dut1 expected_run", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("dut1 pass",      int'(if1.pass),      e.pass);
          chk("dut1 err_count", int'(if1.err_count), e.err);
          chk("dut1 fail_vec",  int'(if1.fail_vec),  e.fv);
          chk("dut1 latency",   cyc - b1_cyc,        e.lat);
        end
      end
      busy1_p = if1.busy;
      done1_p = if1.done;
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, " dut0 a"},    int'(if0.a), 0);
    chk({tag, " dut0 b"},    int'(if0.b), 0);
    chk({tag, " dut0 done"}, int'(if0.done), 0);
    chk({tag, " dut0 pass"}, int'(if0.pass), 0);
    chk({tag, " dut0 err"},  int'(if0.err_count), 0);
    chk({tag, " dut0 fv"},   int'(if0.fail_vec), 0);
    chk({tag, " dut1 a"},    int'(if1.a), 0);
    chk({tag, " dut1 b"},    int'(if1.b), 0);
    chk({tag, " dut1 done"}, int'(if1.done), 0);
    chk({tag, " dut1 pass"}, int'(if1.pass), 0);
    chk({tag, " dut1 err"},  int'(if1.err_count), 0);
    chk({tag, " dut1 fv"},   int'(if1.fail_vec), 0);
  endtask

  task automatic pulse(input logic s0, input logic s1);
    @(negedge clk);
    if0.start = s0;
    if1.start = s1;
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    chk("pending_runs", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = int'($urandom_range(0, 2));
    if0.start = 1'(($urandom_range(0, 1)));
    if1.start = 1'(($urandom_range(0, 1)));
    repeat (3) @(negedge clk);
    check_cleared("reset");
    chk("reset dut0 busy", int'(if0.busy), 0);
    chk("reset dut1 busy", int'(if1.busy), 0);
    if0.start = 1'b0;
    if1.start = 1'b0;
    mode      = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Correct gate block
    q0.push_back('{1, 0, 0, 20});
    q1.push_back('{1, 0, 0, 8});
    pulse(1'b1, 1'b1);
    wait_idle();

    // xor stuck at 0: fails on vectors 01 and 10
    mode = 1;
    q0.push_back('{0, 2, 6, 20});
    q1.push_back('{0, 2, 6, 8});
    pulse(1'b1, 1'b1);
    wait_idle();

    // All outputs inverted: 24 mismatches, saturating at 15 on the 4-bit counter
    mode = 2;
    q0.push_back('{0, 24, 15, 20});
    q1.push_back('{0, 15, 15, 8});
    pulse(1'b1, 1'b1);
    wait_idle();

    // Restart from a failing DONE with a correct model
    mode = 0;
    q0.push_back('{1, 0, 0, 20});
    q1.push_back('{1, 0, 0, 8});
    @(negedge clk);
    if0.start = 1'b1;
    if1.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    check_cleared("restart");
    chk("restart dut0 busy", int'(if0.busy), 1);
    chk("restart dut1 busy", int'(if1.busy), 1);
    wait_idle();

    // start held high through a run must not restart it
    q0.push_back('{1, 0, 0, 20});
    @(negedge clk);
    if0.start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if0.done) break;
    end
    if0.start = 1'b0;
    wait_idle();

    // Reset during vector 2 of dut0
    q1.push_back('{1, 0, 0, 8});
    pulse(1'b1, 1'b1);
    repeat (11) @(negedge clk);
    chk("midrun dut0 busy", int'(if0.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_cleared("midrun_reset");
    chk("midrun dut0 busy_rst", int'(if0.busy), 0);
    chk("midrun pending", q0.size() + q1.size(), 0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    q0.push_back('{1, 0, 0, 20});
    q1.push_back('{1, 0, 0, 8});
    pulse(1'b1, 1'b1);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
